// File: rtl/reg_bank_sb.sv
// reg_bank_sb: sixteen 16-bit registers with a per-register pending scoreboard; REG_BANK_R0_ZERO_EN hardwires r0 to zero.
// Latency: writeback data and pending updates are visible 1 cycle after the edge; iss_ready is combinational.
// Backpressure: iss_ready drops on a WAW hazard unless a same-cycle writeback retires that destination.
module reg_bank_sb (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wb_valid,
    input  logic [3:0]  wb_addr,
    input  logic [15:0] wb_data,
    input  logic        iss_valid,
    input  logic [3:0]  iss_dest,
    output logic        iss_ready,
    output logic [15:0] r0,
    output logic [15:0] r1,
    output logic [15:0] r2,
    output logic [15:0] r3,
    output logic [15:0] r4,
    output logic [15:0] r5,
    output logic [15:0] r6,
    output logic [15:0] r7,
    output logic [15:0] r8,
    output logic [15:0] r9,
    output logic [15:0] r10,
    output logic [15:0] r11,
    output logic [15:0] r12,
    output logic [15:0] r13,
    output logic [15:0] r14,
    output logic [15:0] r15,
    output logic [15:0] pending
);

    logic [15:0] rf_q [16];
    logic [15:0] pend_q;
    logic [15:0] pend_d;
    logic        wb_hit;
    logic        iss_acc;
    logic        wb_en;
    logic        iss_set;

    // Readiness looks only at the scoreboard and the writeback port, never at iss_valid.
    assign wb_hit    = wb_valid && (wb_addr == iss_dest);
    assign iss_ready = !pend_q[iss_dest] || wb_hit;
    assign iss_acc   = iss_valid && iss_ready;

`ifdef REG_BANK_R0_ZERO_EN
    assign wb_en   = wb_valid && (wb_addr != 4'd0);
    assign iss_set = iss_acc && (iss_dest != 4'd0);
`else
    assign wb_en   = wb_valid;
    assign iss_set = iss_acc;
`endif

    // Set is applied after clear so a same-register issue keeps the bit pending.
    always_comb begin
        pend_d = pend_q;
        if (wb_en) begin
            pend_d[wb_addr] = 1'b0;
        end
        if (iss_set) begin
            pend_d[iss_dest] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_q <= 16'h0000;
        end else begin
            pend_q <= pend_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) begin
                rf_q[i] <= 16'h0000;
            end
        end else if (wb_en) begin
            rf_q[wb_addr] <= wb_data;
        end
    end

`ifdef REG_BANK_R0_ZERO_EN
    assign r0 = 16'h0000;
`else
    assign r0 = rf_q[0];
`endif
    assign r1      = rf_q[1];
    assign r2      = rf_q[2];
    assign r3      = rf_q[3];
    assign r4      = rf_q[4];
    assign r5      = rf_q[5];
    assign r6      = rf_q[6];
    assign r7      = rf_q[7];
    assign r8      = rf_q[8];
    assign r9      = rf_q[9];
    assign r10     = rf_q[10];
    assign r11     = rf_q[11];
    assign r12     = rf_q[12];
    assign r13     = rf_q[13];
    assign r14     = rf_q[14];
    assign r15     = rf_q[15];
    assign pending = pend_q;

endmodule

// File: tb/tb_reg_bank_sb.sv
// Self-checking bench for reg_bank_sb: directed scenarios followed by random traffic against a scoreboard model.
module tb_reg_bank_sb;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        wb_valid;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data;
    logic        iss_valid;
    logic [3:0]  iss_dest;
    logic        iss_ready;
    logic [15:0] r0, r1, r2, r3, r4, r5, r6, r7;
    logic [15:0] r8, r9, r10, r11, r12, r13, r14, r15;
    logic [15:0] pending;
    logic [15:0] rv [16];

    int checks   = 0;
    int failures = 0;

    logic [15:0] mr [16];
    logic [15:0] mp;

    always #5 clk = ~clk;

    reg_bank_sb dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .wb_valid  (wb_valid),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .iss_valid (iss_valid),
        .iss_dest  (iss_dest),
        .iss_ready (iss_ready),
        .r0 (r0),   .r1 (r1),   .r2 (r2),   .r3 (r3),
        .r4 (r4),   .r5 (r5),   .r6 (r6),   .r7 (r7),
        .r8 (r8),   .r9 (r9),   .r10(r10),  .r11(r11),
        .r12(r12),  .r13(r13),  .r14(r14),  .r15(r15),
        .pending   (pending)
    );

    assign rv[0]  = r0;  assign rv[1]  = r1;  assign rv[2]  = r2;  assign rv[3]  = r3;
    assign rv[4]  = r4;  assign rv[5]  = r5;  assign rv[6]  = r6;  assign rv[7]  = r7;
    assign rv[8]  = r8;  assign rv[9]  = r9;  assign rv[10] = r10; assign rv[11] = r11;
    assign rv[12] = r12; assign rv[13] = r13; assign rv[14] = r14; assign rv[15] = r15;

`ifdef REG_BANK_R0_ZERO_EN
    localparam bit R0Z = 1'b1;
`else
    localparam bit R0Z = 1'b0;
`endif

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) mr[i] = 16'h0000;
        mp = 16'h0000;
    endtask

    function automatic logic model_ready(input logic [3:0] id, input logic wv, input logic [3:0] wa);
        return (mp[id] == 1'b0) || (wv && (wa == id));
    endfunction

    task automatic check_state(input string ctx);
        for (int i = 0; i < 16; i++) chk($sformatf("%s_r%0d", ctx, i), rv[i], mr[i]);
        chk($sformatf("%s_pending", ctx), pending, mp);
    endtask

    // One cycle: drive at negedge, check iss_ready, advance model at posedge, check state after.
    task automatic step(input string ctx, input logic wv, input logic [3:0] wa, input logic [15:0] wd,
                        input logic iv, input logic [3:0] id);
        logic rdy;
        @(negedge clk);
        wb_valid = wv; wb_addr = wa; wb_data = wd; iss_valid = iv; iss_dest = id;
        #1;
        rdy = model_ready(id, wv, wa);
        chk($sformatf("%s_iss_ready", ctx), {15'd0, iss_ready}, {15'd0, rdy});
        @(posedge clk);
        if (reset_n) begin
            if (wv && !(R0Z && wa == 4'd0)) begin
                mr[wa] = wd;
                mp[wa] = 1'b0;
            end
            if (iv && rdy && !(R0Z && id == 4'd0)) mp[id] = 1'b1;
        end
        #1;
        check_state(ctx);
    endtask

    task automatic idle(input string ctx);
        step(ctx, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0);
    endtask

    initial begin
        logic [31:0] rnd;
        logic [3:0]  a;
        logic [3:0]  d;
        reset_n = 1'b0;
        wb_valid = 1'b0; wb_addr = 4'd0; wb_data = 16'h0000;
        iss_valid = 1'b1; iss_dest = 4'd0;
        model_clear();

        // Reset state and iss_ready during reset for a few destinations
        #3;
        check_state("rst");
        for (int i = 0; i < 16; i += 5) begin
            iss_dest = i[3:0];
            #1;
            chk($sformatf("rst_ready_d%0d", i), {15'd0, iss_ready}, 16'h0001);
        end
        @(negedge clk);
        iss_valid = 1'b0;
        reset_n = 1'b1;
        idle("post_rst");

        // Plain write
        step("wr3", 1'b1, 4'd3, 16'h1234, 1'b0, 4'd0);
        chk("wr3_const", r3, 16'h1234);

        // WAW stall then release
        step("iss7", 1'b0, 4'd0, 16'h0000, 1'b1, 4'd7);
        step("stall7", 1'b0, 4'd0, 16'h0000, 1'b1, 4'd7);
        chk("stall7_ready", {15'd0, iss_ready}, 16'h0000);
        chk("stall7_pending", pending, 16'h0080);
        step("wb7", 1'b1, 4'd7, 16'h00AA, 1'b0, 4'd7);
        chk("wb7_pending", pending, 16'h0000);
        chk("wb7_r7", r7, 16'h00AA);

        // Same-register collision: set wins
        step("iss9", 1'b0, 4'd0, 16'h0000, 1'b1, 4'd9);
        step("col9", 1'b1, 4'd9, 16'h5555, 1'b1, 4'd9);
        chk("col9_r9", r9, 16'h5555);
        chk("col9_pend", pending, 16'h0200);

        // Different-register collision
        step("clr9", 1'b1, 4'd9, 16'h5555, 1'b0, 4'd0);
        step("iss2", 1'b0, 4'd0, 16'h0000, 1'b1, 4'd2);
        step("col2_14", 1'b1, 4'd2, 16'h0F0F, 1'b1, 4'd14);
        chk("col2_r2", r2, 16'h0F0F);
        chk("col2_pend", pending, 16'h4000);
        step("clr14", 1'b1, 4'd14, 16'h0000, 1'b0, 4'd0);

        // Register 0 behaviour
        step("wb0", 1'b1, 4'd0, 16'hFFFF, 1'b0, 4'd0);
        step("iss0", 1'b0, 4'd0, 16'h0000, 1'b1, 4'd0);
        iss_dest = 4'd0; iss_valid = 1'b0;
        #1;
        chk("r0_val", r0, R0Z ? 16'h0000 : 16'hFFFF);
        chk("r0_pend0", {15'd0, pending[0]}, R0Z ? 16'h0000 : 16'h0001);
        chk("r0_ready", {15'd0, iss_ready}, R0Z ? 16'h0001 : 16'h0000);
        step("clr0", 1'b1, 4'd0, 16'h0000, 1'b0, 4'd0);

        // Random traffic with frequent same-register collisions
        for (int n = 0; n < 400; n++) begin
            rnd = $urandom;
            a = rnd[3:0];
            d = rnd[4] ? a : rnd[11:8];
            step("rand", rnd[12], a, rnd[31:16], rnd[13] | rnd[14], d);
        end

        // Asynchronous mid-cycle reset discards state and in-flight requests
        step("wr5", 1'b1, 4'd5, 16'hBEEF, 1'b1, 4'd6);
        #2;
        reset_n = 1'b0;
        #1;
        model_clear();
        check_state("async_rst");
        chk("async_rst_r5", r5, 16'h0000);
        chk("async_rst_pend", pending, 16'h0000);
        step("in_rst", 1'b1, 4'd4, 16'h1111, 1'b1, 4'd4);
        chk("in_rst_r4", r4, 16'h0000);
        @(negedge clk);
        reset_n = 1'b1;
        wb_valid = 1'b0; iss_valid = 1'b0;
        #1;
        chk("after_rst_ready", {15'd0, iss_ready}, 16'h0001);
        step("first_wr", 1'b1, 4'd4, 16'h1111, 1'b1, 4'd8);
        chk("first_wr_r4", r4, 16'h1111);
        chk("first_wr_pend", pending, 16'h0100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
